// File: rtl/sixteen_bit_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier with a full 2*WIDTH-bit product.
// The operands are registered, and the partial-product array is reduced by
// ripple-carry adder rows. The sum is then registered. The result is a fixed
// 2-clock latency, and a new operand pair is accepted every cycle.
//
// Ports:
//   clk       - system clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset, has priority over in_valid
//   in_valid  - qualifies A and B this cycle
//   A, B      - unsigned operands
//   out_valid - P holds a valid product this cycle
//   P         - unsigned product A*B
module sixteen_bit_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] P
);

    // Stage 1: operand registers, captured unconditionally
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               v1_q;

    // Stage 2: product register
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_d;
    logic               v2_q;

    // Temporaries for the adder array
    logic [2*WIDTH-1:0] pp;
    logic               carry;
    logic               s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            p_q  <= '0;
            v2_q <= 1'b0;
        end else begin
            a_q  <= A;
            b_q  <= B;
            v1_q <= in_valid;
            p_q  <= p_d;
            v2_q <= v1_q;
        end
    end

    // Row 0 seeds the accumulator; each following row adds its shifted
    // partial product through a bit-serial ripple-carry chain. The carry out
    // of the top bit is always zero because the product fits in 2*WIDTH bits.
    always_comb begin
        pp    = '0;
        carry = 1'b0;
        s     = 1'b0;
        p_d   = {{WIDTH{1'b0}}, {WIDTH{b_q[0]}} & a_q};
        for (int r = 1; r < WIDTH; r++) begin
            pp    = {{WIDTH{1'b0}}, {WIDTH{b_q[r]}} & a_q} << r;
            carry = 1'b0;
            for (int k = 0; k < 2 * WIDTH; k++) begin
                s      = p_d[k] ^ pp[k] ^ carry;
                carry  = (p_d[k] & pp[k]) | (carry & (p_d[k] ^ pp[k]));
                p_d[k] = s;
            end
        end
    end

    assign P         = p_q;
    assign out_valid = v2_q;

endmodule

// File: tb/tb_sixteen_bit_multiplier.sv
module tb_sixteen_bit_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        out_valid;
    logic [15:0] P;

    int n_vec = 0;
    int n_err = 0;

    sixteen_bit_multiplier #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .P        (P)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one pair, advance one clock, then compare the outputs seen just
    // after that edge. Output after step k reflects the pair of step k-1.
    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic v, input logic [15:0] exp_p, input logic exp_v);
        A        = a;
        B        = b;
        in_valid = v;
        @(posedge clk);
        #1;
        check({tag, ".P"}, P, exp_p);
        check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_v});
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;

        // Reset held 3 cycles with max operands valid: nothing may leak out
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step("reset", 8'hFF, 8'hFF, 1'b1, 16'd0, 1'b0);
        rst_n = 1'b1;

        step("rel0",   8'd255, 8'd255, 1'b1, 16'd0,     1'b0);
        step("rel1",   8'd9,   8'd8,   1'b1, 16'd65025, 1'b1);
        step("9x8",    8'd8,   8'd9,   1'b1, 16'd72,    1'b1);
        step("8x9",    8'd0,   8'd200, 1'b1, 16'd72,    1'b1);
        step("0x200",  8'd1,   8'd255, 1'b1, 16'd0,     1'b1);
        step("1x255",  8'd255, 8'd255, 1'b1, 16'd255,   1'b1);
        step("ffxff",  8'd128, 8'd2,   1'b1, 16'hFE01,  1'b1);
        step("128x2",  8'd3,   8'd5,   1'b1, 16'd256,   1'b1);
        // Back-to-back stream
        step("s3x5",   8'd16,  8'd16,  1'b1, 16'd15,    1'b1);
        step("s16x16", 8'd255, 8'd1,   1'b1, 16'd256,   1'b1);
        step("s255x1", 8'd170, 8'd85,  1'b1, 16'd255,   1'b1);
        step("s170x85",8'd7,   8'd7,   1'b0, 16'd14450, 1'b1);
        // Gaps: invalid operands still produce P but out_valid stays low
        step("inv7x7", 8'd6,   8'd11,  1'b1, 16'd49,    1'b0);
        step("g6x11",  8'd0,   8'd0,   1'b0, 16'd66,    1'b1);
        step("gap0",   8'd0,   8'd0,   1'b0, 16'd0,     1'b0);
        step("gap1",   8'd12,  8'd12,  1'b1, 16'd0,     1'b0);
        step("g12x12", 8'd0,   8'd0,   1'b0, 16'd144,   1'b1);
        step("gap2",   8'd0,   8'd0,   1'b0, 16'd0,     1'b0);
        // Mid-stream reset discards products in flight
        step("pre0",   8'd20,  8'd30,  1'b1, 16'd0,     1'b0);
        step("pre1",   8'd40,  8'd50,  1'b1, 16'd600,   1'b1);
        rst_n = 1'b0;
        step("midrst", 8'd60,  8'd70,  1'b1, 16'd0,     1'b0);
        rst_n = 1'b1;
        step("post0",  8'd0,   8'd0,   1'b0, 16'd0,     1'b0);
        step("post1",  8'd5,   8'd6,   1'b1, 16'd0,     1'b0);
        step("post2",  8'd0,   8'd0,   1'b0, 16'd30,    1'b1);
        step("post3",  8'd0,   8'd0,   1'b0, 16'd0,     1'b0);

        // Exhaustive stream; each output is the product of the previous pair
        pa = 8'd0;
        pb = 8'd0;
        for (int i = 0; i < 65536; i++) begin
            A        = i[15:8];
            B        = i[7:0];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i > 0) begin
                check("exh.P", P, 16'(pa) * 16'(pb));
                check("exh.out_valid", {15'd0, out_valid}, 16'd1);
            end
            pa = i[15:8];
            pb = i[7:0];
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("exh.last", P, 16'(pa) * 16'(pb));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
